spi_frame_master: RTL

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

---
 rtl/spi_frame_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 (CPOL=0, CPHA=0) master that shifts out a
// frame of FRAME_BYTES bytes from a TX buffer and stores the bytes it
// receives in an RX buffer. Each byte has its own slave-select window and
// is separated from the next by GAP_CYCLES idle cycles.
// Optional feature: define SPI_FRAME_MASTER_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0x00) and to check the CRC byte returned by the slave.
module spi_frame_master #(
  parameter int FRAME_BYTES = 8,
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       iSTART,
  input  logic       iWR,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_DATA,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_DATA,
  output logic       oFRAME_n,
  output logic       oSS_n,
  output logic       oSCK,
  output logic       oMOSI,
  input  logic       iMISO,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oCRC_ERR
);

  localparam int BUF_N = 20;
`ifdef SPI_FRAME_MASTER_CRC_EN
  localparam int NBYTES = FRAME_BYTES + 1;
`else
  localparam int NBYTES = FRAME_BYTES;
`endif
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  PAY_END   = 5'(FRAME_BYTES);
  localparam logic [4:0]  LAST_IDX  = 5'(NBYTES - 1);
  localparam logic [4:0]  BUF_END   = 5'(BUF_N);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic        sck;
  logic [4:0]  byte_idx;
  logic [4:0]  idx_load;
  logic        load;
  logic [7:0]  tx_sh, rx_sh;
  logic [7:0]  tx_byte;
  logic [7:0]  tx_mem [0:BUF_N-1];
  logic [7:0]  rx_mem [0:BUF_N-1];
  logic        done;
  logic        half_end, gap_end, byte_end;

  assign half_end = (cnt == HALF_LAST);
  assign gap_end  = (cnt == GAP_LAST);
  assign byte_end = (state == SHIFT) && half_end && sck && (bit_cnt == 3'd7);

  assign oSCK  = sck;
  assign oMOSI = tx_sh[7];
  assign oDONE = done;

  // State register
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode, byte-load requests and envelope outputs
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    idx_load  = byte_idx;
    oBUSY     = 1'b1;
    oSS_n     = 1'b1;
    oFRAME_n  = 1'b0;
    case (state)
      IDLE: begin
        oBUSY    = 1'b0;
        oFRAME_n = 1'b1;
        if (iSTART) state_nxt = SETUP;
      end
      SETUP: begin
        if (gap_end) begin
          state_nxt = SHIFT;
          load      = 1'b1;
          idx_load  = 5'd0;
        end
      end
      SHIFT: begin
        oSS_n = 1'b0;
        if (byte_end) state_nxt = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = SHIFT;
            load      = 1'b1;
            idx_load  = byte_idx + 5'd1;
          end
        end
      end
      HOLD: begin
        oFRAME_n = 1'b1;
        if (cnt == 16'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SPI_FRAME_MASTER_CRC_EN
  logic [7:0] tx_crc, rx_crc;
  logic       crc_bad, crc_err;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Running CRCs of sent and received payload; error flag latched with oDONE
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      tx_crc  <= 8'h00;
      rx_crc  <= 8'h00;
      crc_bad <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      if (state == IDLE && iSTART) begin
        tx_crc  <= 8'h00;
        rx_crc  <= 8'h00;
        crc_bad <= 1'b0;
        crc_err <= 1'b0;
      end
      if (load && idx_load < PAY_END) tx_crc <= crc8_byte(tx_crc, tx_mem[idx_load]);
      if (byte_end) begin
        if (byte_idx < PAY_END) rx_crc <= crc8_byte(rx_crc, rx_sh);
        else                    crc_bad <= (rx_sh != rx_crc);
      end
      if (state == HOLD && cnt == 16'd1) crc_err <= crc_bad;
    end
  end

  assign oCRC_ERR = crc_err;
`else
  assign oCRC_ERR = 1'b0;
`endif

  // Byte presented to the shifter: payload from TX buffer, or the CRC byte
  always_comb begin
    tx_byte = (idx_load < BUF_END) ? tx_mem[idx_load] : 8'h00;
`ifdef SPI_FRAME_MASTER_CRC_EN
    if (idx_load == PAY_END) tx_byte = tx_crc;
`endif
  end

  // Phase counter, SCK generation and the TX/RX shift registers
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      byte_idx <= '0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= (state == HOLD) && (cnt == 16'd1);
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else if (state == SHIFT && half_end)     cnt <= '0;
      else                                     cnt <= cnt + 16'd1;
      if (load) begin
        byte_idx <= idx_load;
        tx_sh    <= tx_byte;
        bit_cnt  <= 3'd0;
      end
      if (state == SHIFT && half_end) begin
        sck <= ~sck;
        if (!sck) begin
          rx_sh <= {rx_sh[6:0], iMISO};
        end else begin
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // TX/RX buffers and the registered RX read port
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int i = 0; i < BUF_N; i++) begin
        tx_mem[i] <= 8'h00;
        rx_mem[i] <= 8'h00;
      end
      oRD_DATA <= 8'h00;
    end else begin
      if (iWR && !oBUSY && iWR_ADDR < PAY_END) tx_mem[iWR_ADDR] <= iWR_DATA;
      if (byte_end && byte_idx < BUF_END) rx_mem[byte_idx] <= rx_sh;
      oRD_DATA <= (iRD_ADDR < BUF_END) ? rx_mem[iRD_ADDR] : 8'h00;
    end
  end

endmodule
